// File: rtl/wb_port_arbiter_if.sv
// Bundle of the write-back, MDU, issue-query and register-file port signals
// seen by the write-port arbiter.
interface wb_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            wb_write_i;
    logic [4:0]      wb_rd_i;
    logic [XLEN-1:0] wb_data_i;
    logic            wb_stall_o;
    logic            mdu_valid_i;
    logic [4:0]      mdu_rd_i;
    logic [XLEN-1:0] mdu_data_i;
    logic            mdu_ready_o;
    logic            iss_alloc_i;
    logic [4:0]      iss_rd_i;
    logic [4:0]      rs1_addr_i;
    logic [4:0]      rs2_addr_i;
    logic            rs1_busy_o;
    logic            rs2_busy_o;
    logic            REG_write_o;
    logic [4:0]      REG_addr_o;
    logic [XLEN-1:0] REG_data_o;

    modport slave (
        input  wb_write_i, wb_rd_i, wb_data_i,
        input  mdu_valid_i, mdu_rd_i, mdu_data_i,
        input  iss_alloc_i, iss_rd_i, rs1_addr_i, rs2_addr_i,
        output wb_stall_o, mdu_ready_o, rs1_busy_o, rs2_busy_o,
        output REG_write_o, REG_addr_o, REG_data_o
    );

    modport master (
        output wb_write_i, wb_rd_i, wb_data_i,
        output mdu_valid_i, mdu_rd_i, mdu_data_i,
        output iss_alloc_i, iss_rd_i, rs1_addr_i, rs2_addr_i,
        input  wb_stall_o, mdu_ready_o, rs1_busy_o, rs2_busy_o,
        input  REG_write_o, REG_addr_o, REG_data_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline write-back and
// one buffered MDU result, with starvation stall and a pending-rd scoreboard.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 3
) (
    input logic               clk,
    input logic               reset_n,
    wb_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } state_t;

    state_t          state_r;
    logic [4:0]      buf_rd_r;
    logic [XLEN-1:0] buf_data_r;
    logic [CW-1:0]   wait_cnt_r;
    logic [31:0]     pending_r;

    logic            wb_req_s;
    logic            starve_s;
    logic            drain_s;
    logic            accept_s;
    logic            port_write_s;
    logic [31:0]     pending_next_s;

    // Source selection: starvation or an idle WB slot lets the buffer drain.
    always_comb begin
        wb_req_s = bus.wb_write_i && (bus.wb_rd_i != 5'd0);
        starve_s = (state_r == ST_HELD) && (wait_cnt_r == LIMIT);
        drain_s  = (state_r == ST_HELD) && (starve_s || !wb_req_s);
        accept_s = (state_r == ST_EMPTY) && bus.mdu_valid_i;
        if (drain_s) begin
            port_write_s    = 1'b1;
            bus.REG_addr_o  = buf_rd_r;
            bus.REG_data_o  = buf_data_r;
        end else if (wb_req_s) begin
            port_write_s    = 1'b1;
            bus.REG_addr_o  = bus.wb_rd_i;
            bus.REG_data_o  = bus.wb_data_i;
        end else begin
            port_write_s    = 1'b0;
            bus.REG_addr_o  = 5'd0;
            bus.REG_data_o  = {XLEN{1'b0}};
        end
        // Gated by reset so a held WB request cannot write during reset.
        bus.REG_write_o = port_write_s && reset_n;
        bus.wb_stall_o  = starve_s;
        bus.mdu_ready_o = (state_r == ST_EMPTY);
        bus.rs1_busy_o  = pending_r[bus.rs1_addr_i];
        bus.rs2_busy_o  = pending_r[bus.rs2_addr_i];
    end

    // Scoreboard next value: drain clears first so a same-cycle alloc wins.
    always_comb begin
        pending_next_s = pending_r;
        if (drain_s) begin
            pending_next_s[buf_rd_r] = 1'b0;
        end else begin
            pending_next_s = pending_next_s;
        end
        if (bus.iss_alloc_i && (bus.iss_rd_i != 5'd0)) begin
            pending_next_s[bus.iss_rd_i] = 1'b1;
        end else begin
            pending_next_s = pending_next_s;
        end
        pending_next_s[0] = 1'b0;
    end

    // Buffer state machine: EMPTY accepts a result, HELD waits for a port slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_EMPTY;
            buf_rd_r   <= 5'd0;
            buf_data_r <= {XLEN{1'b0}};
            wait_cnt_r <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    // A result for x0 is consumed by the handshake and dropped.
                    if (accept_s && (bus.mdu_rd_i != 5'd0)) begin
                        state_r    <= ST_HELD;
                        buf_rd_r   <= bus.mdu_rd_i;
                        buf_data_r <= bus.mdu_data_i;
                        wait_cnt_r <= {CW{1'b0}};
                    end else begin
                        state_r    <= ST_EMPTY;
                    end
                end
                ST_HELD: begin
                    if (drain_s) begin
                        state_r    <= ST_EMPTY;
                        wait_cnt_r <= {CW{1'b0}};
                    end else if (wait_cnt_r != LIMIT) begin
                        wait_cnt_r <= wait_cnt_r + CW'(1'b1);
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                default: begin
                    state_r    <= ST_EMPTY;
                    wait_cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Pending-destination scoreboard register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= 32'd0;
        end else begin
            pending_r <= pending_next_s;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized checks of wb_port_arbiter against a transaction-level
// model of the buffer, loss counter and pending set.
module tb_wb_port_arbiter;
    localparam int XLEN = 32;
    localparam int STARVE_LIMIT = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    wb_port_arbiter_if #(.XLEN(XLEN)) bus ();

    wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one held result, how many slots it has lost, pending set.
    bit              m_valid;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    int              m_loss;
    bit              m_pend [32];
    bit              m_last_stall;
    bit              m_last_hs;
    bit              e_ready, e_stall, e_drain, e_write;
    logic [4:0]      e_addr;
    logic [XLEN-1:0] e_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_loss = 0;
        m_last_stall = 1'b0;
        m_last_hs = 1'b0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    endtask

    task automatic idle();
        bus.wb_write_i = 1'b0; bus.wb_rd_i = 5'd0; bus.wb_data_i = 32'd0;
        bus.mdu_valid_i = 1'b0; bus.mdu_rd_i = 5'd0; bus.mdu_data_i = 32'd0;
        bus.iss_alloc_i = 1'b0; bus.iss_rd_i = 5'd0;
        bus.rs1_addr_i = 5'd0; bus.rs2_addr_i = 5'd0;
    endtask

    // Let inputs settle, predict this cycle's outputs and compare.
    task automatic settle();
        bit wbreq;
        #1;
        wbreq   = bus.wb_write_i && (bus.wb_rd_i != 5'd0);
        e_ready = !m_valid;
        e_stall = m_valid && (m_loss == STARVE_LIMIT);
        e_drain = m_valid && (e_stall || !wbreq);
        e_write = e_drain || wbreq;
        e_addr  = e_drain ? m_rd : bus.wb_rd_i;
        e_data  = e_drain ? m_data : bus.wb_data_i;
        chk("mdu_ready", bus.mdu_ready_o, e_ready);
        chk("wb_stall", bus.wb_stall_o, e_stall);
        chk("reg_write", bus.REG_write_o, e_write);
        if (e_write) begin
            chk("reg_addr", bus.REG_addr_o, e_addr);
            chk("reg_data", bus.REG_data_o, e_data);
        end
        chk("rs1_busy", bus.rs1_busy_o, (bus.rs1_addr_i != 5'd0) && m_pend[bus.rs1_addr_i]);
        chk("rs2_busy", bus.rs2_busy_o, (bus.rs2_addr_i != 5'd0) && m_pend[bus.rs2_addr_i]);
    endtask

    // Clock edge plus model update from the inputs present at that edge.
    task automatic tick();
        @(posedge clk);
        m_last_stall = e_stall;
        m_last_hs = e_ready && bus.mdu_valid_i;
        if (e_drain) begin
            m_pend[m_rd] = 1'b0;
            m_valid = 1'b0;
        end else if (m_valid) begin
            m_loss++;
        end
        if (m_last_hs && bus.mdu_rd_i != 5'd0) begin
            m_valid = 1'b1;
            m_rd = bus.mdu_rd_i;
            m_data = bus.mdu_data_i;
            m_loss = 0;
        end
        if (bus.iss_alloc_i && bus.iss_rd_i != 5'd0) m_pend[bus.iss_rd_i] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        idle();
        model_reset();
        // Reset holds the port closed even with a live WB request.
        bus.wb_write_i = 1'b1; bus.wb_rd_i = 5'd5; bus.wb_data_i = 32'h55;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_write", bus.REG_write_o, 1'b0);
        chk("rst_ready", bus.mdu_ready_o, 1'b1);
        chk("rst_stall", bus.wb_stall_o, 1'b0);
        chk("rst_busy", bus.rs1_busy_o, 1'b0);
        reset_n = 1'b1;
        settle();
        chk("rel_write", bus.REG_write_o, 1'b1);
        chk("rel_addr", bus.REG_addr_o, 5'd5);
        tick();

        // MDU result drains through an idle port.
        idle(); bus.iss_alloc_i = 1'b1; bus.iss_rd_i = 5'd7; settle(); tick();
        idle(); bus.mdu_valid_i = 1'b1; bus.mdu_rd_i = 5'd7; bus.mdu_data_i = 32'h1234;
        bus.rs1_addr_i = 5'd7; settle();
        chk("drain_busy_pre", bus.rs1_busy_o, 1'b1);
        tick();
        idle(); bus.rs1_addr_i = 5'd7; settle();
        chk("drain_write", bus.REG_write_o, 1'b1);
        chk("drain_addr", bus.REG_addr_o, 5'd7);
        chk("drain_data", bus.REG_data_o, 32'h1234);
        chk("drain_ready", bus.mdu_ready_o, 1'b0);
        tick();
        idle(); bus.rs1_addr_i = 5'd7; settle();
        chk("drain_ready_back", bus.mdu_ready_o, 1'b1);
        chk("drain_busy_post", bus.rs1_busy_o, 1'b0);
        tick();

        // Starvation: WB wins STARVE_LIMIT times, then the buffer forces a stall.
        idle(); bus.iss_alloc_i = 1'b1; bus.iss_rd_i = 5'd9;
        bus.mdu_valid_i = 1'b1; bus.mdu_rd_i = 5'd9; bus.mdu_data_i = 32'hAA; settle(); tick();
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            idle(); bus.wb_write_i = 1'b1; bus.wb_rd_i = 5'(3 + i); bus.wb_data_i = 32'(100 + i);
            settle();
            chk("starve_wb_addr", bus.REG_addr_o, 5'(3 + i));
            chk("starve_no_stall", bus.wb_stall_o, 1'b0);
            tick();
        end
        idle(); bus.wb_write_i = 1'b1; bus.wb_rd_i = 5'd6; bus.wb_data_i = 32'h600; settle();
        chk("starve_stall", bus.wb_stall_o, 1'b1);
        chk("starve_buf_addr", bus.REG_addr_o, 5'd9);
        chk("starve_buf_data", bus.REG_data_o, 32'hAA);
        tick();
        settle();
        chk("starve_replay_stall", bus.wb_stall_o, 1'b0);
        chk("starve_replay_addr", bus.REG_addr_o, 5'd6);
        chk("starve_replay_data", bus.REG_data_o, 32'h600);
        tick();

        // x0 handling on both sources.
        idle(); bus.wb_write_i = 1'b1; settle();
        chk("x0_wb_nowrite", bus.REG_write_o, 1'b0);
        tick();
        idle(); bus.mdu_valid_i = 1'b1; bus.mdu_rd_i = 5'd14; bus.mdu_data_i = 32'hE; settle(); tick();
        idle(); bus.wb_write_i = 1'b1; settle();
        chk("x0_wb_drain_addr", bus.REG_addr_o, 5'd14);
        tick();
        idle(); bus.mdu_valid_i = 1'b1; bus.mdu_data_i = 32'hDEAD; settle(); tick();
        idle(); settle();
        chk("x0_mdu_ready", bus.mdu_ready_o, 1'b1);
        chk("x0_mdu_nowrite", bus.REG_write_o, 1'b0);
        tick();

        // Same-cycle set and clear of the scoreboard.
        idle(); bus.mdu_valid_i = 1'b1; bus.mdu_rd_i = 5'd12; bus.mdu_data_i = 32'hC; settle(); tick();
        idle(); bus.iss_alloc_i = 1'b1; bus.iss_rd_i = 5'd12; settle(); tick();
        idle(); bus.rs1_addr_i = 5'd12; settle();
        chk("setclr_same", bus.rs1_busy_o, 1'b1);
        tick();
        idle(); bus.mdu_valid_i = 1'b1; bus.mdu_rd_i = 5'd12; bus.mdu_data_i = 32'hC; settle(); tick();
        idle(); bus.iss_alloc_i = 1'b1; bus.iss_rd_i = 5'd13; settle(); tick();
        idle(); bus.rs1_addr_i = 5'd12; bus.rs2_addr_i = 5'd13; settle();
        chk("setclr_cleared", bus.rs1_busy_o, 1'b0);
        chk("setclr_set", bus.rs2_busy_o, 1'b1);
        tick();

        // Reset while a result is held with two lost slots.
        idle(); bus.iss_alloc_i = 1'b1; bus.iss_rd_i = 5'd9;
        bus.mdu_valid_i = 1'b1; bus.mdu_rd_i = 5'd9; bus.mdu_data_i = 32'h99; settle(); tick();
        for (int i = 0; i < 2; i++) begin
            idle(); bus.wb_write_i = 1'b1; bus.wb_rd_i = 5'd4; settle(); tick();
        end
        bus.rs1_addr_i = 5'd9;
        reset_n = 1'b0;
        #1;
        chk("midrst_write", bus.REG_write_o, 1'b0);
        chk("midrst_stall", bus.wb_stall_o, 1'b0);
        chk("midrst_ready", bus.mdu_ready_o, 1'b1);
        chk("midrst_busy", bus.rs1_busy_o, 1'b0);
        model_reset();
        @(negedge clk);
        idle();
        reset_n = 1'b1;

        // Randomized traffic honouring the hold rules for stalled WB and pending MDU.
        for (int n = 0; n < 400; n++) begin
            if (!m_last_stall) begin
                bus.wb_write_i = ($urandom_range(0, 3) != 0);
                bus.wb_rd_i = 5'($urandom_range(0, 31));
                bus.wb_data_i = $urandom;
            end
            if (!(bus.mdu_valid_i && !m_last_hs)) begin
                bus.mdu_valid_i = ($urandom_range(0, 9) < 4);
                bus.mdu_rd_i = 5'($urandom_range(0, 31));
                bus.mdu_data_i = $urandom;
            end
            bus.iss_alloc_i = ($urandom_range(0, 3) == 0);
            bus.iss_rd_i = 5'($urandom_range(0, 31));
            bus.rs1_addr_i = 5'($urandom_range(0, 31));
            bus.rs2_addr_i = 5'($urandom_range(0, 31));
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter and sequencer for the single register-file write port, sitting between the MEM/WB write-back path and the register file. Shares the port between the in-order pipeline write-back and results from the variable-latency multiply/divide unit (MDU). Holds one MDU result in a buffer and bounds its wait with a starvation counter that stalls the pipeline. Keeps a 32-entry pending-destination scoreboard so issue logic can detect RAW hazards on outstanding MDU results.

## Interface
- XLEN, 32, data width of register writes
- STARVE_LIMIT, 3, maximum number of cycles the buffered MDU result loses to write-back before the pipeline is stalled (≥1)

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- wb_write_i  in  1  write-back stage requests a register write
- wb_rd_i  in  5  write-back destination register
- wb_data_i  in  XLEN  write-back data (already muxed mem/alu)
- wb_stall_o  out  1  freeze pipeline; WB inputs must be held stable next cycle
- mdu_valid_i  in  1  MDU result valid
- mdu_rd_i  in  5  MDU destination register
- mdu_data_i  in  XLEN  MDU result
- mdu_ready_o  out  1  arbiter can accept an MDU result
- iss_alloc_i  in  1  issue stage dispatches an MDU op
- iss_rd_i  in  5  destination of dispatched MDU op
- rs1_addr_i, rs2_addr_i  in  5 each  source registers queried by issue
- rs1_busy_o, rs2_busy_o  out  1 each  queried register has an outstanding MDU result
- REG_write_o  out  1  register-file write enable
- REG_addr_o  out  5  register-file write address
- REG_data_o  out  XLEN  register-file write data

## Operation
- Definitions: WB request = wb_write_i && wb_rd_i≠0. MDU handshake = mdu_valid_i && mdu_ready_o.
- State: buf_valid, buf_rd, buf_data, wait_cnt (width clog2(STARVE_LIMIT+1), saturating), pending[31:0] (bit 0 always 0).
- Two states: EMPTY (buf_valid=0), HELD (buf_valid=1). mdu_ready_o = !buf_valid.
- EMPTY: handshake with mdu_rd_i≠0 → HELD, buffer loads rd/data, wait_cnt=0. Handshake with mdu_rd_i=0 → consumed, discarded, stay EMPTY.
- HELD, port selection each cycle (priority order):
  - wait_cnt==STARVE_LIMIT: wb_stall_o=1, buffer drives port, → EMPTY.
  - no WB request: buffer drives port, → EMPTY.
  - WB request: WB drives port, wait_cnt+1, stay HELD.
- EMPTY: WB request drives port directly; no request → REG_write_o=0.
- Port outputs combinational: REG_write_o/REG_addr_o/REG_data_o from the selected source. While wb_stall_o=1, WB data is not written this cycle and is presented again next cycle.
- wb_stall_o asserted only in the starvation case; it is a function of registered state only (buf_valid && wait_cnt==STARVE_LIMIT).
- Scoreboard: iss_alloc_i with iss_rd_i≠0 sets pending[iss_rd_i]. Buffer drain clears pending[buf_rd]. Same-cycle set and clear of the same register: set wins. A discarded rd=0 result leaves pending unchanged.
- rsN_busy_o = pending[rsN_addr_i], combinational; address 0 → 0.
- WB and MDU writing the same rd is prevented by issue via the scoreboard; the arbiter performs no WAW check.

## Timing
- Reset (reset_n low, asynchronous): buf_valid=0, wait_cnt=0, pending=0. Outputs: mdu_ready_o=1, wb_stall_o=0, rs*_busy_o=0, REG_write_o forced 0 while reset_n is low.
- MDU latency: result accepted at edge N, written to the register file at the earliest in cycle N+1 (combinational write at edge N+2 of the regfile).
- Worst case: write occurs in cycle N+1+STARVE_LIMIT.
- Throughput: one MDU result per 2 cycles maximum, since mdu_ready_o stays low during the drain cycle.
- mdu_ready_o is registered-derived. The MDU must hold valid/rd/data until the handshake.
- Reset mid-operation discards the buffered result and clears the scoreboard. No write is issued.

## Test plan
- Reset: hold reset_n low with wb_write_i=1, rd=5 → REG_write_o=0, mdu_ready_o=1, busy outputs 0. Release reset → WB write to x5 passes through the same cycle.
- MDU idle-port drain: iss_alloc rd=7, then MDU valid rd=7 data=0x1234 with no WB → rs1_busy(7)=1 until written. Next cycle REG_write_o=1, addr=7, data=0x1234. pending[7] clears and mdu_ready_o returns to 1 the cycle after.
- Starvation, STARVE_LIMIT=3: buffer holds rd=9, WB requests every cycle → WB wins for 3 cycles. 4th cycle: wb_stall_o=1 and port writes x9. Next cycle the held WB write is completed.
- x0 handling: WB rd=0 → REG_write_o=0 and buffer drains that cycle. MDU result rd=0 → accepted, never written, mdu_ready_o stays 1.
- Simultaneous set/clear: buffer draining rd=12 while iss_alloc rd=12 → pending[12]=1 afterwards. Distinct rd=12/13 → pending[12]=0, pending[13]=1.
- Reset mid-operation: buffer HELD with wait_cnt=2, assert reset_n low → no write, buf_valid=0, wb_stall_o=0, pending cleared immediately.
